// File: rtl/sub_2p_pkg.sv
// Shared constants and helpers for the two-slice pipelined subtractor.
package sub_2p_pkg;

  localparam int WIDTH_DEF  = 15;
  localparam int WIDTH1_DEF = 7;
  localparam int WIDTH2_DEF = 8;

  // x - y is formed as x + ~y + 1; carry out of the word means "no borrow".
  localparam logic CIN_SUB = 1'b1;

  // Two's-complement overflow of x - y: operand signs differ and the
  // result sign disagrees with the minuend.
  function automatic logic signed_ovf(input logic xs, input logic ys, input logic msb);
    return (xs != ys) && (msb != xs);
  endfunction

endpackage

// File: rtl/sub_2p_if.sv
// Operand/result bundle with valid/ready handshakes on both sides.
interface sub_2p_if
  import sub_2p_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output x, y, in_valid, out_ready,
    input  in_ready, diff, borrow, ovf, out_valid
  );

  modport slave (
    input  x, y, in_valid, out_ready,
    output in_ready, diff, borrow, ovf, out_valid
  );

endinterface

// File: rtl/sub_slice.sv
// Parameterised slice adder: {cout, result} = dataa + datab + cin.
module sub_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  // Widen by one bit so the carry is kept rather than truncated.
  assign {cout, result} = {1'b0, dataa} + {1'b0, datab} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/sub_2p.sv
// Two-stage pipelined subtractor with the inter-slice carry registered
// between stages and a stallable valid/ready pipeline.
module sub_2p
  import sub_2p_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WIDTH1 = WIDTH1_DEF,
  parameter int WIDTH2 = WIDTH2_DEF
) (
  input  logic     clk,
  input  logic     reset,
  sub_2p_if.slave  bus
);

  logic              v1, v2;
  logic              adv1, adv2, accept;

  logic [WIDTH1-1:0] d1, d1_next;
  logic              c1, c1_next;
  logic [WIDTH2-1:0] p1, p1_next;
  logic              c1m, c1m_next;
  logic              xs, ys;

  logic [WIDTH2-1:0] u2;
  logic              c2;

  logic [WIDTH-1:0]  diff_q;
  logic              borrow_q, ovf_q;

  logic [WIDTH1-1:0] y_lo_n;
  logic [WIDTH2-1:0] y_hi_n;

  assign y_lo_n = ~bus.y[WIDTH1-1:0];
  assign y_hi_n = ~bus.y[WIDTH-1:WIDTH1];

  // Stage 1: LSB slice takes the subtract carry-in; the MSB slice is
  // pre-summed without it and fixed up next cycle with the registered c1.
  sub_slice #(.WIDTH(WIDTH1)) u_lsb (
    .dataa  (bus.x[WIDTH1-1:0]),
    .datab  (y_lo_n),
    .cin    (CIN_SUB),
    .result (d1_next),
    .cout   (c1_next)
  );

  sub_slice #(.WIDTH(WIDTH2)) u_msb (
    .dataa  (bus.x[WIDTH-1:WIDTH1]),
    .datab  (y_hi_n),
    .cin    (1'b0),
    .result (p1_next),
    .cout   (c1m_next)
  );

  sub_slice #(.WIDTH(WIDTH2)) u_carry (
    .dataa  (p1),
    .datab  ({WIDTH2{1'b0}}),
    .cin    (c1),
    .result (u2),
    .cout   (c2)
  );

  // A stage may advance when it is empty or the stage after it advances.
  assign adv2   = ~v2 | bus.out_ready;
  assign adv1   = ~v1 | adv2;
  assign accept = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = reset & adv1;
  assign bus.out_valid = v2;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          diff_q   <= {u2, d1};
          borrow_q <= ~(c1m | c2);
          ovf_q    <= signed_ovf(xs, ys, u2[WIDTH2-1]);
        end
      end
      if (adv1) begin
        v1 <= bus.in_valid;
      end
    end
  end

  // NOTE: stage-1 data needs no reset; it is only ever consumed behind v1.
  always_ff @(posedge clk) begin
    if (accept) begin
      d1  <= d1_next;
      c1  <= c1_next;
      p1  <= p1_next;
      c1m <= c1m_next;
      xs  <= bus.x[WIDTH-1];
      ys  <= bus.y[WIDTH-1];
    end
  end

endmodule
